// File: rtl/charlie_pkg.sv
// Shared definitions for the charlieplexed pin bank: pin/key counts, scan states
// and the {row,col} key numbering that the LED frame buffer also uses.
package charlie_pkg;

    localparam int CHARLIE_PINS = 8;
    localparam int KEY_COUNT    = 64;
    localparam int KEY_IDX_W    = 6;

    typedef enum logic [1:0] {
        SETTLE,
        SAMPLE,
        UPDATE
    } scan_state_e;

    typedef logic [2:0]           pin_idx_t;
    typedef logic [KEY_IDX_W-1:0] key_idx_t;

    function automatic key_idx_t key_idx_of(input pin_idx_t row, input pin_idx_t col);
        return {row, col};
    endfunction

    function automatic logic [CHARLIE_PINS-1:0] pin_onehot(input pin_idx_t pin);
        logic [CHARLIE_PINS-1:0] one;
        one = 1;
        return one << pin;
    endfunction

endpackage

// File: rtl/charlie_keyscan_if.sv
// Pin and key-report bundle of the key scanner; master is the scanner,
// slave is whatever owns the pins and consumes key events.
interface charlie_keyscan_if;
    import charlie_pkg::*;

    logic [CHARLIE_PINS-1:0] uio_in;
    logic [CHARLIE_PINS-1:0] uio_out;
    logic [CHARLIE_PINS-1:0] uio_oe;
    logic [KEY_COUNT-1:0]    key_state;
    logic                    key_event;
    key_idx_t                key_index;
    logic                    key_pressed;
    logic                    scan_done;

    modport master (
        input  uio_in,
        output uio_out, uio_oe, key_state, key_event, key_index, key_pressed, scan_done
    );

    modport slave (
        output uio_in,
        input  uio_out, uio_oe, key_state, key_event, key_index, key_pressed, scan_done
    );

endinterface

// File: rtl/charlie_debounce_bank.sv
// Per-key debounce counters and debounced state, updated through one
// read-modify-write port that visits a single key per cycle.
module charlie_debounce_bank
    import charlie_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 upd_en,
    input  key_idx_t             upd_idx,
    input  logic                 raw_bit,
    output logic [KEY_COUNT-1:0] key_state,
    output logic                 flip,
    output logic                 new_state
);

    // cnt+1 == DEBOUNCE_SCANS rewritten so the compare stays inside 3 bits
    localparam logic [2:0] DB_LAST = 3'(DEBOUNCE_SCANS - 1);

    logic [2:0]           cnt_view [KEY_COUNT];
    logic [KEY_COUNT-1:0] state_view;
    logic [2:0]           cnt_rd;
    logic [2:0]           cnt_d;
    logic                 cur_state;

    always_comb begin
        cur_state = state_view[upd_idx];
        cnt_rd    = cnt_view[upd_idx];
        flip      = 1'b0;
        cnt_d     = 3'd0;
        if (upd_en && (raw_bit != cur_state)) begin
            if (cnt_rd == DB_LAST) begin
                flip = 1'b1;
            end else begin
                cnt_d = cnt_rd + 3'd1;
            end
        end
        new_state = ~cur_state;
    end

    generate
        for (genvar gi = 0; gi < KEY_COUNT; gi++) begin : g_key
            logic       sel;
            logic [2:0] cnt_q;
            logic       state_q;

            assign sel = upd_en && (upd_idx == key_idx_t'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q   <= 3'd0;
                    state_q <= 1'b0;
                end else if (sel) begin
                    cnt_q <= cnt_d;
                    if (flip) begin
                        state_q <= new_state;
                    end
                end
            end

            assign cnt_view[gi]   = cnt_q;
            assign state_view[gi] = state_q;
        end
    endgenerate

    assign key_state = state_view;

endmodule

// File: rtl/charlie_keyscan.sv
// Charlieplexed key-matrix scanner: drives one pin per row, latches the other
// seven, then walks the eight columns through the debounce bank.
module charlie_keyscan
    import charlie_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic              clk,
    input  logic              rst,
    charlie_keyscan_if.master bus
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    scan_state_e             state_q, state_d;
    pin_idx_t                row_q, row_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [CHARLIE_PINS-1:0] row_raw_q, row_raw_d;
    logic [CHARLIE_PINS-1:0] drive_q, drive_d;
    logic                    scan_done_q, scan_done_d;
    logic                    key_event_q, key_event_d;
    key_idx_t                key_index_q, key_index_d;
    logic                    key_pressed_q, key_pressed_d;

    logic     upd_en;
    key_idx_t upd_idx;
    logic     raw_bit;
    logic     flip;
    logic     new_state;

    assign upd_en  = (state_q == UPDATE);
    assign upd_idx = key_idx_of(row_q, cnt_q[2:0]);
    assign raw_bit = row_raw_q[cnt_q[2:0]];

    charlie_debounce_bank #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .upd_en   (upd_en),
        .upd_idx  (upd_idx),
        .raw_bit  (raw_bit),
        .key_state(bus.key_state),
        .flip     (flip),
        .new_state(new_state)
    );

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        row_raw_d = row_raw_q;
        unique case (state_q)
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SAMPLE: begin
                // the driven pin reads back its own drive, never a key
                state_d   = UPDATE;
                cnt_d     = 4'd0;
                row_raw_d = bus.uio_in & ~pin_onehot(row_q);
            end
            UPDATE: begin
                if (cnt_q == 4'd7) begin
                    state_d = SETTLE;
                    cnt_d   = 4'd0;
                    row_d   = row_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = SETTLE;
                cnt_d   = 4'd0;
            end
        endcase

        // pins float during UPDATE so the sensed node discharges through the pull-downs
        drive_d       = upd_en ? '0 : pin_onehot(row_q);
        scan_done_d   = upd_en && (row_q == 3'd7) && (cnt_q == 4'd7);
        key_event_d   = flip;
        key_index_d   = flip ? upd_idx : key_index_q;
        key_pressed_d = flip ? new_state : key_pressed_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SETTLE;
            row_q         <= 3'd0;
            cnt_q         <= 4'd0;
            row_raw_q     <= '0;
            drive_q       <= '0;
            scan_done_q   <= 1'b0;
            key_event_q   <= 1'b0;
            key_index_q   <= '0;
            key_pressed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            cnt_q         <= cnt_d;
            row_raw_q     <= row_raw_d;
            drive_q       <= drive_d;
            scan_done_q   <= scan_done_d;
            key_event_q   <= key_event_d;
            key_index_q   <= key_index_d;
            key_pressed_q <= key_pressed_d;
        end
    end

    assign bus.uio_out     = drive_q;
    assign bus.uio_oe      = drive_q;
    assign bus.scan_done   = scan_done_q;
    assign bus.key_event   = key_event_q;
    assign bus.key_index   = key_index_q;
    assign bus.key_pressed = key_pressed_q;

endmodule
